slow_clk_monitor: RTL and testbench
===================================

Name: slow_clk_monitor

Overview:
Receive-side counterpart to the board's slow-clock dividers. Samples an asynchronous slow square wave (e.g. a 1 Hz tick from another board or divider) in the 100 MHz Clk domain. Produces one-cycle edge ticks, measures period and high time in Clk cycles, and flags loss of the input. Used by lab designs that must lock onto, or check, an externally generated slow clock.

Parameters:
CNT_W, 28, width of the period, high-time and idle counters.
TIMEOUT, 60000000, number of Clk cycles with no ClkIn edge before Lost asserts. Must satisfy 2 <= TIMEOUT < 2^CNT_W.

Ports:
Clk  input  1  system clock, 100 MHz
Rst  input  1  synchronous reset, active-high
ClkIn  input  1  asynchronous slow clock under measurement
RiseTick  output  1  one-cycle pulse per synchronized rising edge of ClkIn
FallTick  output  1  one-cycle pulse per synchronized falling edge of ClkIn
Period  output  CNT_W  Clk cycles between the last two rising edges
HighTime  output  CNT_W  Clk cycles from the last rising edge to the following falling edge
PeriodValid  output  1  one-cycle pulse when Period is updated
Locked  output  1  level: at least one complete period measured since reset or loss
Lost  output  1  level: no ClkIn edge for TIMEOUT cycles

Behaviour:
- Clk is the clock. Rst is synchronous and active-high.
- Reset values: all outputs 0, the 2-flop synchronizer and previous-sample register 0, all counters 0, state WAIT_FIRST. Reset mid-measurement discards everything in one cycle.
- Synchronizer: s0 <= ClkIn, s1 <= s0, prev <= s1.
  - rise = s1 & ~prev; fall = ~s1 & prev.
  - RiseTick <= rise and FallTick <= fall (registered). A ClkIn transition is seen as a tick 3 Clk edges after first being sampled.
  - ClkIn held high through reset release produces one rise. This is treated as a normal first rise.
- PerCnt:
  - Set to 1 on the rise cycle.
  - Otherwise incremented each cycle, saturating at 2^CNT_W-1 (no wrap).
- States:
  - WAIT_FIRST: on rise, go to MEASURE and set PerCnt <= 1. No PeriodValid.
  - MEASURE: on rise, Period <= PerCnt (the pre-update value, equal to the exact rise-to-rise distance), PeriodValid <= 1, Locked <= 1, PerCnt <= 1, go to LOCKED.
  - LOCKED: on rise, same update as in MEASURE; stay in LOCKED.
  - In MEASURE and LOCKED, on fall: HighTime <= PerCnt.
  - In WAIT_FIRST, falls are ignored for HighTime.
- Idle timer IdleCnt:
  - Cleared on any rise or fall; otherwise increments. Runs in every state.
  - When IdleCnt reaches TIMEOUT-1 with no edge that cycle: Lost <= 1, Locked <= 0, state <= WAIT_FIRST, IdleCnt holds.
  - Lost clears on the next rise. That rise is the first rise of a new measurement, so no PeriodValid is issued.
- Period and HighTime hold their last values through loss and re-acquire. They change only on a valid update.
- Simultaneous events: an edge and the timeout in the same cycle resolve in favour of the edge (no Lost). Rise and fall cannot coincide.
- Saturated PerCnt at a rise reports Period = 2^CNT_W-1. This cannot occur when TIMEOUT < 2^CNT_W, because loss fires first.
- PeriodValid and the Period update occur in the same cycle as RiseTick.

Test Plan:
- CNT_W=16, TIMEOUT=100. Rst held 5 cycles with ClkIn=0 -> all outputs 0. After 100 idle cycles -> Lost=1, Locked=0.
- ClkIn toggling every 4 Clk cycles (period 8) -> first rise gives RiseTick and no PeriodValid. Second rise gives PeriodValid with Period=8 and Locked=1. Each fall gives HighTime=4.
- Duty change, high 3 / low 9 -> Period=12, HighTime=3. RiseTick and FallTick are each exactly 1 cycle wide, 3 edges after the ClkIn transition.
- Steady period 8, then ClkIn frozen high -> Lost=1 exactly 100 cycles after the last edge, Locked=0, Period still 8. Resume toggling -> Lost drops on the first rise; PeriodValid resumes at the second rise.
- Edge arriving on the cycle IdleCnt would hit TIMEOUT-1 -> Lost stays 0 and IdleCnt is cleared.
- Rst asserted mid-period while Locked -> next cycle all outputs 0 and state WAIT_FIRST. ClkIn high at release -> one RiseTick and no PeriodValid.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// Measures an asynchronous slow square wave in the Clk domain: edge ticks,
// rise-to-rise period, high time, lock indication and loss-of-input detection.
module slow_clk_monitor #(
  parameter int CNT_W   = 28,
  parameter int TIMEOUT = 60000000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ClkIn,
  output logic             RiseTick,
  output logic             FallTick,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] HighTime,
  output logic             PeriodValid,
  output logic             Locked,
  output logic             Lost
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    LOCKED     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             s0_q, s1_q, prev_q;
  logic             rise_tick_q, fall_tick_q, period_valid_q;
  logic             locked_q, lost_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic rise, fall, any_edge, timeout;

  always_comb begin
    rise     = s1_q & ~prev_q;
    fall     = ~s1_q & prev_q;
    any_edge = rise | fall;
    // An edge in the same cycle as the timeout wins.
    timeout  = ~any_edge && (idle_cnt_q == IDLE_LIMIT);

    per_cnt_d = per_cnt_q;
    if (rise)
      per_cnt_d = CNT_ONE;
    else if (per_cnt_q != CNT_MAX)
      per_cnt_d = per_cnt_q + CNT_ONE;

    idle_cnt_d = idle_cnt_q;
    if (any_edge)
      idle_cnt_d = '0;
    else if (!timeout)
      idle_cnt_d = idle_cnt_q + CNT_ONE;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= WAIT_FIRST;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      prev_q         <= 1'b0;
      rise_tick_q    <= 1'b0;
      fall_tick_q    <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
      period_q       <= '0;
      high_time_q    <= '0;
      per_cnt_q      <= '0;
      idle_cnt_q     <= '0;
    end else begin
      s0_q           <= ClkIn;
      s1_q           <= s0_q;
      prev_q         <= s1_q;
      rise_tick_q    <= rise;
      fall_tick_q    <= fall;
      period_valid_q <= 1'b0;
      per_cnt_q      <= per_cnt_d;
      idle_cnt_q     <= idle_cnt_d;

      if (timeout) begin
        lost_q   <= 1'b1;
        locked_q <= 1'b0;
        state_q  <= WAIT_FIRST;
      end else begin
        if (rise)
          lost_q <= 1'b0;
        case (state_q)
          WAIT_FIRST: begin
            // First rise only starts the count; falls here carry no high time.
            if (rise)
              state_q <= MEASURE;
          end
          MEASURE, LOCKED: begin
            if (rise) begin
              period_q       <= per_cnt_q;
              period_valid_q <= 1'b1;
              locked_q       <= 1'b1;
              state_q        <= LOCKED;
            end
            if (fall)
              high_time_q <= per_cnt_q;
          end
          default: state_q <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign RiseTick    = rise_tick_q;
  assign FallTick    = fall_tick_q;
  assign Period      = period_q;
  assign HighTime    = high_time_q;
  assign PeriodValid = period_valid_q;
  assign Locked      = locked_q;
  assign Lost        = lost_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with CNT_W=16, TIMEOUT=100.
module tb_slow_clk_monitor;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             ClkIn;
  logic             RiseTick, FallTick, PeriodValid, Locked, Lost;
  logic [CNT_W-1:0] Period, HighTime;

  int vectors     = 0;
  int miscompares = 0;

  // Per-drive capture of what the DUT emitted during the drive window.
  int               rise_cnt, fall_cnt, pv_cnt, rise_pos, fall_pos, pv_unaligned;
  logic [CNT_W-1:0] pv_period;

  slow_clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .ClkIn(ClkIn),
    .RiseTick(RiseTick), .FallTick(FallTick),
    .Period(Period), .HighTime(HighTime),
    .PeriodValid(PeriodValid), .Locked(Locked), .Lost(Lost)
  );

  always #5 Clk = ~Clk;

  // Set ClkIn at a negedge, then observe n following negedges.
  task automatic drive(input logic v, input int n);
    rise_cnt = 0; fall_cnt = 0; pv_cnt = 0; rise_pos = 0; fall_pos = 0;
    pv_unaligned = 0; pv_period = '0;
    ClkIn = v;
    for (int i = 1; i <= n; i++) begin
      @(negedge Clk);
      if (RiseTick === 1'b1) begin rise_cnt++; rise_pos = i; end
      if (FallTick === 1'b1) begin fall_cnt++; fall_pos = i; end
      if (PeriodValid === 1'b1) begin
        pv_cnt++;
        pv_period = Period;
        if (RiseTick !== 1'b1) pv_unaligned++;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; ClkIn = 1'b0;
    repeat (5) @(negedge Clk);
    vectors++; if ({RiseTick, FallTick, PeriodValid, Locked, Lost} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000", {RiseTick, FallTick, PeriodValid, Locked, Lost}); end
    vectors++; if (Period !== 16'd0) begin
      miscompares++; $display("FAIL reset_period: got %0d expected 0", Period); end
    vectors++; if (HighTime !== 16'd0) begin
      miscompares++; $display("FAIL reset_hightime: got %0d expected 0", HighTime); end
    Rst = 1'b0;
    drive(1'b0, 99);
    vectors++; if (Lost !== 1'b0 || rise_cnt !== 0) begin
      miscompares++; $display("FAIL idle_99: got lost=%0b rises=%0d expected lost=0 rises=0", Lost, rise_cnt); end
    drive(1'b0, 1);
    vectors++; if (Lost !== 1'b1 || Locked !== 1'b0) begin
      miscompares++; $display("FAIL idle_100: got lost=%0b locked=%0b expected lost=1 locked=0", Lost, Locked); end
  endtask

  task automatic test_period8;
    drive(1'b1, 4);
    vectors++; if (rise_cnt !== 1 || rise_pos !== 3 || pv_cnt !== 0) begin
      miscompares++; $display("FAIL p8_first_rise: got rises=%0d pos=%0d pv=%0d expected 1 3 0", rise_cnt, rise_pos, pv_cnt); end
    vectors++; if (Lost !== 1'b0) begin
      miscompares++; $display("FAIL p8_lost_clear: got %0b expected 0", Lost); end
    drive(1'b0, 4);
    vectors++; if (fall_cnt !== 1 || fall_pos !== 3 || HighTime !== 16'd4 || Locked !== 1'b0) begin
      miscompares++; $display("FAIL p8_first_fall: got falls=%0d pos=%0d high=%0d locked=%0b expected 1 3 4 0", fall_cnt, fall_pos, HighTime, Locked); end
    drive(1'b1, 4);
    vectors++; if (pv_cnt !== 1 || pv_period !== 16'd8 || pv_unaligned !== 0) begin
      miscompares++; $display("FAIL p8_period: got pv=%0d period=%0d unaligned=%0d expected 1 8 0", pv_cnt, pv_period, pv_unaligned); end
    vectors++; if (Locked !== 1'b1) begin
      miscompares++; $display("FAIL p8_locked: got %0b expected 1", Locked); end
    drive(1'b0, 4);
    vectors++; if (HighTime !== 16'd4) begin
      miscompares++; $display("FAIL p8_hightime: got %0d expected 4", HighTime); end
  endtask

  task automatic test_duty;
    drive(1'b1, 3);
    vectors++; if (rise_cnt !== 1 || rise_pos !== 3 || pv_period !== 16'd8) begin
      miscompares++; $display("FAIL duty_rise1: got rises=%0d pos=%0d period=%0d expected 1 3 8", rise_cnt, rise_pos, pv_period); end
    drive(1'b0, 9);
    vectors++; if (rise_cnt !== 0 || fall_cnt !== 1 || fall_pos !== 3 || HighTime !== 16'd3) begin
      miscompares++; $display("FAIL duty_fall1: got rises=%0d falls=%0d pos=%0d high=%0d expected 0 1 3 3", rise_cnt, fall_cnt, fall_pos, HighTime); end
    drive(1'b1, 3);
    vectors++; if (fall_cnt !== 0 || pv_cnt !== 1 || pv_period !== 16'd12) begin
      miscompares++; $display("FAIL duty_period12: got falls=%0d pv=%0d period=%0d expected 0 1 12", fall_cnt, pv_cnt, pv_period); end
    drive(1'b0, 9);
    vectors++; if (HighTime !== 16'd3) begin
      miscompares++; $display("FAIL duty_hightime: got %0d expected 3", HighTime); end
    drive(1'b1, 3);
    vectors++; if (Period !== 16'd12) begin
      miscompares++; $display("FAIL duty_period_again: got %0d expected 12", Period); end
    drive(1'b0, 9);
  endtask

  task automatic test_loss_and_resume;
    drive(1'b1, 4);
    vectors++; if (pv_period !== 16'd12) begin
      miscompares++; $display("FAIL loss_prev_period: got %0d expected 12", pv_period); end
    drive(1'b0, 4);
    drive(1'b1, 4);
    vectors++; if (pv_period !== 16'd8) begin
      miscompares++; $display("FAIL loss_steady8: got %0d expected 8", pv_period); end
    drive(1'b1, 98);
    vectors++; if (Lost !== 1'b0) begin
      miscompares++; $display("FAIL loss_at_99: got %0b expected 0", Lost); end
    drive(1'b1, 1);
    vectors++; if (Lost !== 1'b1 || Locked !== 1'b0 || Period !== 16'd8) begin
      miscompares++; $display("FAIL loss_at_100: got lost=%0b locked=%0b period=%0d expected 1 0 8", Lost, Locked, Period); end
    drive(1'b0, 4);
    vectors++; if (Lost !== 1'b1 || HighTime !== 16'd4) begin
      miscompares++; $display("FAIL resume_fall: got lost=%0b high=%0d expected 1 4", Lost, HighTime); end
    drive(1'b1, 4);
    vectors++; if (Lost !== 1'b0 || pv_cnt !== 0 || Locked !== 1'b0) begin
      miscompares++; $display("FAIL resume_rise1: got lost=%0b pv=%0d locked=%0b expected 0 0 0", Lost, pv_cnt, Locked); end
    drive(1'b0, 4);
    vectors++; if (HighTime !== 16'd4) begin
      miscompares++; $display("FAIL resume_high: got %0d expected 4", HighTime); end
    drive(1'b1, 4);
    vectors++; if (pv_cnt !== 1 || pv_period !== 16'd8 || Locked !== 1'b1) begin
      miscompares++; $display("FAIL resume_rise2: got pv=%0d period=%0d locked=%0b expected 1 8 1", pv_cnt, pv_period, Locked); end
  endtask

  task automatic test_edge_at_timeout;
    // Last rise was registered 3 steps into the previous 4-step drive.
    drive(1'b1, 96);
    vectors++; if (Lost !== 1'b0) begin
      miscompares++; $display("FAIL edge_to_pre: got %0b expected 0", Lost); end
    drive(1'b0, 5);
    vectors++; if (Lost !== 1'b0 || fall_pos !== 3 || HighTime !== 16'd100 || Locked !== 1'b1) begin
      miscompares++; $display("FAIL edge_to_boundary: got lost=%0b pos=%0d high=%0d locked=%0b expected 0 3 100 1", Lost, fall_pos, HighTime, Locked); end
    drive(1'b0, 97);
    vectors++; if (Lost !== 1'b0) begin
      miscompares++; $display("FAIL edge_to_cleared: got %0b expected 0", Lost); end
    drive(1'b0, 1);
    vectors++; if (Lost !== 1'b1 || Locked !== 1'b0) begin
      miscompares++; $display("FAIL edge_to_relost: got lost=%0b locked=%0b expected 1 0", Lost, Locked); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 4);
    vectors++; if (Locked !== 1'b1) begin
      miscompares++; $display("FAIL mid_relock: got %0b expected 1", Locked); end
    drive(1'b0, 2);
    Rst = 1'b1; ClkIn = 1'b1;
    @(negedge Clk);
    vectors++; if ({RiseTick, FallTick, PeriodValid, Locked, Lost} !== 5'b0 || Period !== 16'd0 || HighTime !== 16'd0) begin
      miscompares++; $display("FAIL mid_reset: got flags=%b period=%0d high=%0d expected 00000 0 0", {RiseTick, FallTick, PeriodValid, Locked, Lost}, Period, HighTime); end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    drive(1'b1, 6);
    vectors++; if (rise_cnt !== 1 || rise_pos !== 3 || pv_cnt !== 0 || Locked !== 1'b0) begin
      miscompares++; $display("FAIL mid_release_rise: got rises=%0d pos=%0d pv=%0d locked=%0b expected 1 3 0 0", rise_cnt, rise_pos, pv_cnt, Locked); end
    drive(1'b0, 4);
    drive(1'b1, 4);
    vectors++; if (pv_cnt !== 1 || pv_period !== 16'd10 || Locked !== 1'b1) begin
      miscompares++; $display("FAIL mid_first_period: got pv=%0d period=%0d locked=%0b expected 1 10 1", pv_cnt, pv_period, Locked); end
  endtask

  initial begin
    test_reset();
    test_period8();
    test_duty();
    test_loss_and_resume();
    test_edge_at_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
